// File: rtl/trace_player_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_player_pkg
// Description : Shared opcode/state enums and record width helpers for the
//               trace ROM, the record decoder and the player FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_player_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_END  = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_STALL  = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    function automatic int tnb_f(input int tree_num);
        return (tree_num > 1) ? $clog2(tree_num) : 1;
    endfunction

    function automatic int iwb_f(input int idlecycle);
        return (idlecycle > 1) ? $clog2(idlecycle) : 1;
    endfunction

    function automatic int aw_f(input int rom_size);
        return (rom_size > 1) ? $clog2(rom_size) : 1;
    endfunction

    // Record width: the wider of an IDLE count and a full PUSH body, plus opcode.
    function automatic int tdb_f(input int idlecycle, input int ptw, input int mtw,
                                 input int tree_num);
        int w_push;
        int w_idle;
        w_push = ptw + tnb_f(tree_num) + mtw + ptw;
        w_idle = iwb_f(idlecycle);
        return ((w_idle > w_push) ? w_idle : w_push) + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_player_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_player_if
// Description : Trace ROM read port plus push/pop command bus of the player.
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_player_if #(
    parameter int PTW       = 16,
    parameter int MTW       = 2,
    parameter int TREE_NUM  = 4,
    parameter int IDLECYCLE = 1024,
    parameter int ROM_SIZE  = 16
) ();
    localparam int c_TNB = trace_player_pkg::tnb_f(TREE_NUM);
    localparam int c_TDB = trace_player_pkg::tdb_f(IDLECYCLE, PTW, MTW, TREE_NUM);
    localparam int c_AW  = trace_player_pkg::aw_f(ROM_SIZE);

    logic                 o_read;
    logic [c_AW-1:0]      o_read_addr;
    logic [c_TDB-1:0]     i_trace_data;
    logic                 i_full;
    logic                 o_push;
    logic [c_TNB-1:0]     o_push_tree_id;
    logic [PTW-1:0]       o_push_priority;
    logic [MTW+PTW-1:0]   o_push_data;
    logic                 o_pop;
    logic [c_TNB-1:0]     o_pop_tree_id;

    modport master (
        output o_read, o_read_addr, o_push, o_push_tree_id, o_push_priority,
               o_push_data, o_pop, o_pop_tree_id,
        input  i_trace_data, i_full
    );

    modport slave (
        input  o_read, o_read_addr, o_push, o_push_tree_id, o_push_priority,
               o_push_data, o_pop, o_pop_tree_id,
        output i_trace_data, i_full
    );
endinterface
`default_nettype wire

// File: rtl/trace_decode.sv
`default_nettype none
// ============================================================================
// Module      : trace_decode
// Description : Combinational splitter of one trace record into its fields.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_decode
    import trace_player_pkg::*;
#(
    parameter int PTW = 16,
    parameter int MTW = 2,
    parameter int TNB = 2,
    parameter int IWB = 10,
    parameter int TDB = 38
) (
    input  logic [TDB-1:0]     i_record,
    output opcode_e            o_opcode,
    output logic [TNB-1:0]     o_push_tree_id,
    output logic [PTW-1:0]     o_push_priority,
    output logic [MTW+PTW-1:0] o_push_data,
    output logic [TNB-1:0]     o_pop_tree_id,
    output logic [IWB-1:0]     o_idle_cnt
);
    // PUSH fields are packed MSB-first directly beneath the opcode.
    localparam int c_FLD_MSB = TDB - 3;

    assign o_opcode        = opcode_e'(i_record[TDB-1 -: 2]);
    assign o_push_tree_id  = i_record[c_FLD_MSB -: TNB];
    assign o_push_priority = i_record[c_FLD_MSB-TNB -: PTW];
    assign o_push_data     = i_record[c_FLD_MSB-TNB-PTW -: MTW+PTW];
    assign o_pop_tree_id   = i_record[TNB-1:0];
    assign o_idle_cnt      = i_record[IWB-1:0];
endmodule
`default_nettype wire

// File: rtl/trace_player.sv
`default_nettype none
// ============================================================================
// Module      : trace_player
// Description : Replays a ROM trace of PUSH/POP/IDLE/END records onto a
//               push/pop command bus, with looping and back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_player
    import trace_player_pkg::*;
#(
    parameter int PTW       = 16,
    parameter int MTW       = 2,
    parameter int TREE_NUM  = 4,
    parameter int IDLECYCLE = 1024,
    parameter int ROM_SIZE  = 16,
    parameter int CTW       = 16,
    parameter int LPW       = 8
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_start,
    input  logic [LPW-1:0]    i_loop_cnt,
    output logic              o_busy,
    output logic              o_finish,
    output logic [CTW-1:0]    o_push_cnt,
    output logic [CTW-1:0]    o_pop_cnt,
    trace_player_if.master    io_trace
);
    localparam int c_TNB = tnb_f(TREE_NUM);
    localparam int c_TDB = tdb_f(IDLECYCLE, PTW, MTW, TREE_NUM);
    localparam int c_IWB = iwb_f(IDLECYCLE);
    localparam int c_AW  = aw_f(ROM_SIZE);
    localparam int c_PDW = MTW + PTW;

    state_e              r_state;
    logic [c_AW-1:0]     r_addr;
    logic [LPW-1:0]      r_loop;
    logic [c_IWB-1:0]    r_dly;
    logic                r_read;
    logic                r_push;
    logic                r_pop;
    logic                r_busy;
    logic                r_finish;
    logic [c_TNB-1:0]    r_push_tree;
    logic [PTW-1:0]      r_push_prio;
    logic [c_PDW-1:0]    r_push_data;
    logic [c_TNB-1:0]    r_pop_tree;
    logic [CTW-1:0]      r_push_cnt;
    logic [CTW-1:0]      r_pop_cnt;

    opcode_e             w_op;
    logic [c_TNB-1:0]    w_push_tree;
    logic [PTW-1:0]      w_push_prio;
    logic [c_PDW-1:0]    w_push_data;
    logic [c_TNB-1:0]    w_pop_tree;
    logic [c_IWB-1:0]    w_idle_cnt;

    logic                w_last;
    logic                w_end;
    logic                w_advance;
    logic                w_issue_push;
    logic                w_issue_pop;
    state_e              w_nx_state;
    logic [c_AW-1:0]     w_nx_addr;
    logic [LPW-1:0]      w_nx_loop;
    logic                w_nx_read;
    logic                w_nx_finish;

    trace_decode #(
        .PTW (PTW),
        .MTW (MTW),
        .TNB (c_TNB),
        .IWB (c_IWB),
        .TDB (c_TDB)
    ) u_decode (
        .i_record        (io_trace.i_trace_data),
        .o_opcode        (w_op),
        .o_push_tree_id  (w_push_tree),
        .o_push_priority (w_push_prio),
        .o_push_data     (w_push_data),
        .o_pop_tree_id   (w_pop_tree),
        .o_idle_cnt      (w_idle_cnt)
    );

    assign w_last = (r_addr == c_AW'(ROM_SIZE - 1));

    // Which cycles retire the current record, and whether that retirement is an END.
    always_comb begin
        w_issue_push = 1'b0;
        w_issue_pop  = 1'b0;
        w_advance    = 1'b0;
        w_end        = w_last;
        case (r_state)
            ST_DECODE: begin
                case (w_op)
                    OP_PUSH: begin
                        w_issue_push = !io_trace.i_full;
                        w_advance    = !io_trace.i_full;
                    end
                    OP_POP: begin
                        w_issue_pop = 1'b1;
                        w_advance   = 1'b1;
                    end
                    OP_IDLE: w_advance = (w_idle_cnt == '0);
                    default: begin
                        w_advance = 1'b1;
                        w_end     = 1'b1;
                    end
                endcase
            end
            ST_STALL: begin
                w_issue_push = !io_trace.i_full;
                w_advance    = !io_trace.i_full;
            end
            ST_DELAY: w_advance = (r_dly == c_IWB'(1));
            default: ;
        endcase
    end

    always_comb begin
        w_nx_state  = ST_FETCH;
        w_nx_addr   = r_addr + 1'b1;
        w_nx_loop   = r_loop;
        w_nx_read   = 1'b1;
        w_nx_finish = 1'b0;
        if (w_end) begin
            if (r_loop != '0) begin
                w_nx_loop = r_loop - 1'b1;
                w_nx_addr = '0;
            end else begin
                w_nx_state  = ST_DONE;
                w_nx_addr   = r_addr;
                w_nx_read   = 1'b0;
                w_nx_finish = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_loop      <= '0;
            r_dly       <= '0;
            r_read      <= 1'b0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
            r_push_tree <= '0;
            r_push_prio <= '0;
            r_push_data <= '0;
            r_pop_tree  <= '0;
            r_push_cnt  <= '0;
            r_pop_cnt   <= '0;
        end else begin
            r_read <= 1'b0;
            r_push <= w_issue_push;
            r_pop  <= w_issue_pop;
            if (w_issue_push && (r_push_cnt != '1)) begin
                r_push_cnt <= r_push_cnt + 1'b1;
            end
            if (w_issue_pop && (r_pop_cnt != '1)) begin
                r_pop_cnt <= r_pop_cnt + 1'b1;
            end
            if (w_issue_pop) begin
                r_pop_tree <= w_pop_tree;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_loop     <= i_loop_cnt;
                        r_addr     <= '0;
                        r_push_cnt <= '0;
                        r_pop_cnt  <= '0;
                        r_finish   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_read     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    // Fields are captured here because the ROM word is only valid this cycle.
                    if (w_op == OP_PUSH) begin
                        r_push_tree <= w_push_tree;
                        r_push_prio <= w_push_prio;
                        r_push_data <= w_push_data;
                        if (io_trace.i_full) begin
                            r_state <= ST_STALL;
                        end
                    end else if ((w_op == OP_IDLE) && (w_idle_cnt != '0)) begin
                        r_dly   <= w_idle_cnt;
                        r_state <= ST_DELAY;
                    end
                end
                ST_STALL: ;
                ST_DELAY: r_dly <= r_dly - 1'b1;
                default:  r_state <= ST_IDLE;
            endcase
            if (w_advance) begin
                r_state  <= w_nx_state;
                r_addr   <= w_nx_addr;
                r_loop   <= w_nx_loop;
                r_read   <= w_nx_read;
                r_finish <= w_nx_finish;
                r_busy   <= !w_nx_finish;
            end
        end
    end

    assign o_busy                   = r_busy;
    assign o_finish                 = r_finish;
    assign o_push_cnt               = r_push_cnt;
    assign o_pop_cnt                = r_pop_cnt;
    assign io_trace.o_read          = r_read;
    assign io_trace.o_read_addr     = r_addr;
    assign io_trace.o_push          = r_push;
    assign io_trace.o_push_tree_id  = r_push_tree;
    assign io_trace.o_push_priority = r_push_prio;
    assign io_trace.o_push_data     = r_push_data;
    assign io_trace.o_pop           = r_pop;
    assign io_trace.o_pop_tree_id   = r_pop_tree;
endmodule
`default_nettype wire

// File: tb/tb_trace_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_player
// Description : Directed scoreboard bench for trace_player (default and CTW=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_player;
    localparam int TDB = 38;

    typedef struct {
        bit is_push;
        int tree;
        int prio;
        int data;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [7:0]  loop_cnt;
    logic        busy, finish, busy2, finish2;
    logic [15:0] push_cnt, pop_cnt;
    logic [1:0]  push_cnt2, pop_cnt2;
    logic [TDB-1:0] rom [16];

    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  n2     = 0;
    ev_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    trace_player_if #(.PTW(16), .MTW(2), .TREE_NUM(4), .IDLECYCLE(1024), .ROM_SIZE(16)) bus ();
    trace_player_if #(.PTW(16), .MTW(2), .TREE_NUM(4), .IDLECYCLE(1024), .ROM_SIZE(16)) bus2 ();

    trace_player #(.PTW(16), .MTW(2), .TREE_NUM(4), .IDLECYCLE(1024), .ROM_SIZE(16),
                   .CTW(16), .LPW(8)) u_dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_start(start), .i_loop_cnt(loop_cnt),
        .o_busy(busy), .o_finish(finish), .o_push_cnt(push_cnt), .o_pop_cnt(pop_cnt),
        .io_trace(bus)
    );

    trace_player #(.PTW(16), .MTW(2), .TREE_NUM(4), .IDLECYCLE(1024), .ROM_SIZE(16),
                   .CTW(2), .LPW(8)) u_dut2 (
        .i_clk(clk), .i_arst_n(rst_n), .i_start(start2), .i_loop_cnt(8'd0),
        .o_busy(busy2), .o_finish(finish2), .o_push_cnt(push_cnt2), .o_pop_cnt(pop_cnt2),
        .io_trace(bus2)
    );

    always @(posedge clk) if (bus.o_read)  bus.i_trace_data  <= rom[bus.o_read_addr];
    always @(posedge clk) if (bus2.o_read) bus2.i_trace_data <= rom[bus2.o_read_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [TDB-1:0] rec_push(input int t, input int p, input int d);
        logic [TDB-1:0] r;
        r = '0;
        r[37:36] = 2'b01;
        r[35:34] = t[1:0];
        r[33:18] = p[15:0];
        r[17:0]  = d[17:0];
        return r;
    endfunction

    function automatic logic [TDB-1:0] rec_pop(input int t);
        logic [TDB-1:0] r;
        r = '0;
        r[37:36] = 2'b10;
        r[1:0]   = t[1:0];
        return r;
    endfunction

    function automatic logic [TDB-1:0] rec_idle(input int n);
        logic [TDB-1:0] r;
        r = '0;
        r[9:0] = n[9:0];
        return r;
    endfunction

    function automatic logic [TDB-1:0] rec_end();
        logic [TDB-1:0] r;
        r = '0;
        r[37:36] = 2'b11;
        return r;
    endfunction

    task automatic exp_push(input int t, input int p, input int d, input int c);
        ev_t e;
        e.is_push = 1'b1; e.tree = t; e.prio = p; e.data = d; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic exp_pop(input int t, input int c);
        ev_t e;
        e.is_push = 1'b0; e.tree = t; e.prio = 0; e.data = 0; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] loops, output int s);
        @(negedge clk);
        loop_cnt = loops;
        start    = 1'b1;
        s        = cyc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int limit);
        int n;
        n = 0;
        while (!finish && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, finish, 1'b1);
    endtask

    // Scoreboard: every push/pop pulse of the main DUT must match the next expectation.
    always @(negedge clk) begin
        ev_t e;
        if (bus.o_push || bus.o_pop) begin
            check("pulse_expected", (q.size() > 0), 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pulse_kind", bus.o_push, e.is_push);
                check("pulse_cycle", cyc, e.cyc);
                if (e.is_push) begin
                    check("push_tree", bus.o_push_tree_id, e.tree);
                    check("push_prio", bus.o_push_priority, e.prio);
                    check("push_data", bus.o_push_data, e.data);
                end else begin
                    check("pop_tree", bus.o_pop_tree_id, e.tree);
                end
            end
        end
    end

    always @(negedge clk) if (bus2.o_push) n2++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int lim;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; loop_cnt = 8'd0;
        bus.i_full = 1'b0; bus2.i_full = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = rec_end();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_finish", finish, 1'b0);
        check("rst_push_cnt", push_cnt, 0);
        check("rst_pop_cnt", pop_cnt, 0);
        check("rst_read", bus.o_read, 1'b0);
        check("rst_push", bus.o_push, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Basic PUSH then POP
        rom[0] = rec_push(1, 5, 9); rom[1] = rec_pop(1); rom[2] = rec_end();
        do_start(8'd0, s);
        exp_push(1, 5, 9, s + 3);
        exp_pop(1, s + 5);
        check("run_busy", busy, 1'b1);
        check("fetch_read", bus.o_read, 1'b1);
        check("fetch_addr", bus.o_read_addr, 0);
        @(negedge clk);
        check("fetch_one_cycle", bus.o_read, 1'b0);
        wait_finish("basic_finish", 50);
        check("basic_done_cyc", cyc, s + 7);
        check("basic_push_cnt", push_cnt, 1);
        check("basic_pop_cnt", pop_cnt, 1);
        check("basic_busy_done", busy, 1'b0);

        // Back-pressure stall
        rom[0] = rec_push(2, 7, 3); rom[1] = rec_end();
        bus.i_full = 1'b1;
        do_start(8'd0, s);
        exp_push(2, 7, 3, s + 7);
        while (cyc < s + 6) @(negedge clk);
        check("stall_no_push_cnt", push_cnt, 0);
        check("stall_busy", busy, 1'b1);
        bus.i_full = 1'b0;
        wait_finish("stall_finish", 50);
        check("stall_push_cnt", push_cnt, 1);

        // IDLE N=10 and N=0 between POPs
        rom[0] = rec_pop(0); rom[1] = rec_idle(10); rom[2] = rec_pop(3);
        rom[3] = rec_idle(0); rom[4] = rec_pop(2); rom[5] = rec_end();
        do_start(8'd0, s);
        exp_pop(0, s + 3);
        exp_pop(3, s + 17);
        exp_pop(2, s + 21);
        wait_finish("idle_finish", 100);
        check("idle_pop_cnt", pop_cnt, 3);

        // Loop twice; a start pulse while busy must be ignored
        rom[0] = rec_push(3, 1, 2); rom[1] = rec_end();
        do_start(8'd2, s);
        exp_push(3, 1, 2, s + 3);
        exp_push(3, 1, 2, s + 7);
        exp_push(3, 1, 2, s + 11);
        while (cyc < s + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_finish("loop_finish", 100);
        check("loop_done_cyc", cyc, s + 13);
        check("loop_push_cnt", push_cnt, 3);

        // Full ROM with no END record: wraps as END after address 15
        for (int k = 0; k < 16; k++) rom[k] = rec_push(k % 4, 100 + k, 1000 + k);
        do_start(8'd0, s);
        for (int k = 0; k < 16; k++) exp_push(k % 4, 100 + k, 1000 + k, s + 3 + 2 * k);
        wait_finish("wrap_finish", 100);
        check("wrap_done_cyc", cyc, s + 33);
        check("wrap_push_cnt", push_cnt, 16);

        // Reset in the middle of a DELAY
        rom[0] = rec_idle(20); rom[1] = rec_pop(1); rom[2] = rec_end();
        do_start(8'd0, s);
        while (cyc < s + 6) @(negedge clk);
        check("delay_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_finish", finish, 1'b0);
        check("arst_pop_tree", bus.o_pop_tree_id, 0);
        check("arst_push_prio", bus.o_push_priority, 0);
        check("arst_push_tree", bus.o_push_tree_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_pop_cnt", pop_cnt, 0);

        // CTW=2 saturation
        for (int k = 0; k < 5; k++) rom[k] = rec_push(k % 4, k, k);
        rom[5] = rec_end();
        n2 = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lim = 0;
        while (!finish2 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        check("sat_finish", finish2, 1'b1);
        check("sat_pushes_seen", n2, 5);
        check("sat_push_cnt", push_cnt2, 2'd3);
        check("sat_pop_cnt", pop_cnt2, 2'd0);

        check("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trace_player.md
TRACE_PLAYER -- requirements
Module: trace_player

Interface
REQ-001 The module SHALL have parameter PTW, default 16, priority/payload field width.
REQ-002 The module SHALL have parameter MTW, default 2, metadata width; payload is MTW+PTW bits.
REQ-003 The module SHALL have parameter TREE_NUM, default 4, logical tree count; TNB = clog2(TREE_NUM).
REQ-004 The module SHALL have parameters IDLECYCLE (default 1024, max idle run), ROM_SIZE (default 16, trace depth), CTW (default 16, counter width) and LPW (default 8, loop-count width).
REQ-005 The module SHALL have ports: i_clk in 1 clock; i_arst_n in 1 asynchronous active-low reset.
REQ-006 The module SHALL have ports: i_start in 1 start pulse; i_loop_cnt in LPW extra replay passes; i_full in 1 downstream push back-pressure.
REQ-007 The module SHALL have ports: o_read out 1 ROM read enable; o_read_addr out clog2(ROM_SIZE) ROM address; i_trace_data in TDB record, valid one cycle after o_read.
REQ-008 The module SHALL have ports: o_push out 1; o_push_tree_id out TNB; o_push_priority out PTW; o_push_data out MTW+PTW.
REQ-009 The module SHALL have ports: o_pop out 1; o_pop_tree_id out TNB; o_busy out 1; o_finish out 1; o_push_cnt out CTW; o_pop_cnt out CTW.

Function
REQ-010 TDB SHALL equal max(clog2(IDLECYCLE), PTW+TNB+MTW+PTW)+2; top 2 bits opcode: 00 IDLE, 01 PUSH, 10 POP, 11 END.
REQ-011 PUSH SHALL decode, MSB to LSB below opcode: tree_id (TNB), priority (PTW), data (MTW+PTW); POP tree_id SHALL be the low TNB bits; IDLE count N SHALL be the low clog2(IDLECYCLE) bits.
REQ-012 FSM states SHALL be IDLE, FETCH, DECODE, STALL, DELAY, DONE.
REQ-013 IDLE: on i_start, latch i_loop_cnt, clear address and counters, go FETCH; o_busy SHALL be 1 in every state except IDLE and DONE.
REQ-014 FETCH SHALL assert o_read for exactly one cycle with o_read_addr, then go DECODE.
REQ-015 DECODE PUSH with i_full=0 SHALL pulse o_push for one cycle with registered fields; with i_full=1 go STALL and issue the push the first cycle i_full=0.
REQ-016 DECODE POP SHALL pulse o_pop for one cycle with o_pop_tree_id; POP SHALL ignore i_full.
REQ-017 DECODE IDLE with N>0 SHALL go DELAY and hold N cycles with no push/pop; N=0 SHALL behave as a no-op record.
REQ-018 After each non-END record the address SHALL increment; if the executed record was at ROM_SIZE-1 it SHALL be treated as END.
REQ-019 At END: if the loop counter is nonzero, decrement it, set address 0 and go FETCH; else go DONE.
REQ-020 DONE SHALL hold o_finish=1 until the next i_start, which restarts as from IDLE; i_start in any other state SHALL be ignored.
REQ-021 o_push_cnt/o_pop_cnt SHALL increment per issued push/pop and saturate at 2^CTW-1.
REQ-022 All outputs SHALL be registered; record throughput SHALL be 2 cycles per unstalled PUSH/POP.

Reset
REQ-023 While i_arst_n=0 all outputs, counters, address and loop counter SHALL be 0 and the FSM SHALL be IDLE, taking effect immediately.
REQ-024 Reset mid-replay SHALL abort the replay with no further push/pop pulse; after release the module SHALL wait for i_start.

Structure
REQ-025 A shared package SHALL hold the opcode enum, FSM state enum and the TDB/TNB width functions, shared with the ROM and reader.
REQ-026 One sub-module, trace_decode (combinational record field splitter), SHALL be used.

Verification
REQ-027 ROM {PUSH t1 p5 d9, POP t1, END}, loop 0, start -> o_push at cycle 3 after start with 1/5/9, o_pop at cycle 5 tree 1, o_finish, counts 1/1.
REQ-028 PUSH with i_full held 4 cycles -> o_push not asserted during stall; asserted once the cycle after i_full falls.
REQ-029 IDLE N=10 between two POPs -> pop pulses separated by 10 + 4 cycles; N=0 -> separation 4.
REQ-030 loop_cnt=2 with one PUSH then END -> exactly 3 pushes, o_push_cnt=3, then o_finish.
REQ-031 Full 16-entry ROM without END -> wrap treated as END after address 15; reset asserted mid-DELAY -> outputs 0 at once, no pulse after release until i_start.
REQ-032 CTW=2, 5 pushes -> o_push_cnt saturates at 3.
